ifu_fetch_queue: RTL and testbench
==================================

Name: ifu_fetch_queue

Overview:
Parametrised multi-wide instruction fetch unit with a decoupling fetch queue between instruction memory and decode. Each cycle it issues one fetch group of FETCH_WIDTH sequential instructions to a fixed 1-cycle-latency instruction memory. Returned groups are buffered in a QUEUE_DEPTH-entry FIFO, and decode drains that FIFO through a valid/ready handshake. A branch/jump redirect (SB, UJ or JALR) squashes the queue and any in-flight fetch, then restarts fetch at the target.

Parameters:
FETCH_WIDTH, 2, instructions per fetch group (power of 2, 1..8)
INST_ADDR_WIDTH, 32, instruction address width in bits
QUEUE_DEPTH, 8, fetch-group entries in the queue (power of 2, >=2)
RESET_PC, 0, PC loaded on reset (4-byte aligned)

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  asynchronous, active-high; clears all state
redirect_valid  in  1  redirect request this cycle
redirect_sel  in  2  1=SB, 2=UJ, 3=JALR; 0 is ignored (treated as no redirect)
sb_type_addr  in  INST_ADDR_WIDTH  SB branch target
uj_type_addr  in  INST_ADDR_WIDTH  UJ jump target
jalr_type_addr  in  INST_ADDR_WIDTH  JALR target
imem_req_valid  out  1  fetch request this cycle
imem_req_addr  out  INST_ADDR_WIDTH  group base address
imem_rdata  in  32*FETCH_WIDTH  group data, lane i at bits [32i+31:32i]; valid exactly 1 cycle after request
out_valid  out  1  queue head holds a valid group
out_ready  in  1  decode accepts head
out_inst  out  32*FETCH_WIDTH  head group instructions
out_pc  out  INST_ADDR_WIDTH  head group base PC
out_pc_plus_4  out  INST_ADDR_WIDTH  out_pc + 4
queue_count  out  clog2(QUEUE_DEPTH)+1  occupied entries

Behaviour:
- Reset, asynchronous: fetch_pc=RESET_PC, count=0, head/tail pointers=0, inflight=0. imem_req_valid=0, out_valid=0, queue_count=0 for as long as reset is high.
- Redirect is active when redirect_valid=1 and redirect_sel!=0. Target is chosen by redirect_sel, and bits [1:0] of the target are forced to 0.
- Request (combinational): imem_req_valid = !reset && !redirect_active && (count + inflight < QUEUE_DEPTH).
  - The check uses registered count; a same-cycle dequeue does not free space for the request.
  - imem_req_addr = fetch_pc.
- On an issued request: fetch_pc += 4*FETCH_WIDTH (wraps modulo 2^INST_ADDR_WIDTH), and inflight<=1 for the next cycle; otherwise inflight<=0.
- Response: in the cycle after an issued request, imem_rdata is enqueued at tail with pc = the requested address, unless redirect_active in that cycle, in which case it is dropped.
  - Enqueue never overflows, because the request check guarantees space.
- Dequeue: occurs when out_valid && out_ready. out_valid = (count!=0). out_inst, out_pc and out_pc_plus_4 are driven combinationally from head. Head and tail pointers wrap at QUEUE_DEPTH.
- Simultaneous enqueue and dequeue: count is unchanged and both pointers advance. This is legal when full only in the sense that enqueue cannot occur when full.
- Redirect at cycle t:
  - At the edge ending t: count=0, head=tail=0, inflight=0, fetch_pc=target. Any response arriving in t is dropped. A dequeue in t still completes to decode, but the queue is cleared anyway.
  - Cycle t+1: imem_req_valid=1, addr=target.
  - Cycle t+2: group enqueued.
  - Cycle t+3: out_valid=1, out_pc=target. Redirect-to-first-output latency is 3 cycles.
- Redirect in consecutive cycles: the last one wins, and no request is issued while redirect_active.
- Reset mid-operation: immediate clear. The next request is at RESET_PC on the first cycle with reset low.
- Steady state with out_ready=1 and no redirects: one request and one group delivered per cycle. The first out_valid comes 2 cycles after reset deassertion (request cycle c, enqueue at end of c+1, out_valid in c+2).

Test Plan:
1. Defaults, imem model returns rdata lane i = addr+4i. Release reset with out_ready=1 → requests at 0x0, 0x8, 0x10, … on consecutive cycles; first out_valid 2 cycles after the first request with out_pc=0x0, out_inst={0x4,0x0}, out_pc_plus_4=0x4; then one group per cycle.
2. Backpressure, out_ready=0 from reset → queue_count climbs to 8 and imem_req_valid drops once count+inflight=8, with no lost or duplicated group. Raise out_ready → out_pc sequence continues 0x0, 0x8, … to 0x38 and fetch resumes at 0x40.
3. SB redirect, redirect_sel=1, sb_type_addr=0x20, while a request is in flight and queue_count=3 → next cycle queue_count=0, out_valid=0, imem_req_addr=0x20; out_valid returns 3 cycles after redirect with out_pc=0x20; the stale response is never output.
4. JALR redirect with jalr_type_addr=0x17 → imem_req_addr=0x14 and out_pc=0x14. UJ redirect with uj_type_addr=0x0 on the same cycle as a dequeue on a full queue → queue empty next cycle, next out_pc=0x0. redirect_sel=0 with redirect_valid=1 → no effect.
5. Back-to-back redirects UJ 0x40 then SB 0x80 → no request during either cycle; the first request after them is at 0x80.
6. Assert reset for half a cycle mid-stream with queue_count=5 → queue_count, out_valid and imem_req_valid go to 0 immediately (asynchronous), and the first request after release is at RESET_PC.

Source files
------------

// File: rtl/ifu_fetch_queue_if.sv
// Fetch-unit bus bundle: redirect inputs, instruction-memory port and decode-side stream.
// The master modport is the fetch unit. The slave modport is the surrounding core or bench.
interface ifu_fetch_queue_if #(
  parameter int FETCH_WIDTH     = 2,
  parameter int INST_ADDR_WIDTH = 32,
  parameter int QUEUE_DEPTH     = 8
);
  logic                            redirect_valid;
  logic [1:0]                      redirect_sel;
  logic [INST_ADDR_WIDTH-1:0]      sb_type_addr;
  logic [INST_ADDR_WIDTH-1:0]      uj_type_addr;
  logic [INST_ADDR_WIDTH-1:0]      jalr_type_addr;
  logic                            imem_req_valid;
  logic [INST_ADDR_WIDTH-1:0]      imem_req_addr;
  logic [32*FETCH_WIDTH-1:0]       imem_rdata;
  logic                            out_valid;
  logic                            out_ready;
  logic [32*FETCH_WIDTH-1:0]       out_inst;
  logic [INST_ADDR_WIDTH-1:0]      out_pc;
  logic [INST_ADDR_WIDTH-1:0]      out_pc_plus_4;
  logic [$clog2(QUEUE_DEPTH):0]    queue_count;

  modport master (
    input  redirect_valid, redirect_sel, sb_type_addr, uj_type_addr, jalr_type_addr,
    input  imem_rdata, out_ready,
    output imem_req_valid, imem_req_addr,
    output out_valid, out_inst, out_pc, out_pc_plus_4, queue_count
  );

  modport slave (
    output redirect_valid, redirect_sel, sb_type_addr, uj_type_addr, jalr_type_addr,
    output imem_rdata, out_ready,
    input  imem_req_valid, imem_req_addr,
    input  out_valid, out_inst, out_pc, out_pc_plus_4, queue_count
  );
endinterface

// File: rtl/ifu_fetch_queue.sv
// Multi-wide instruction fetch unit. It issues sequential fetch groups to a 1-cycle imem and
// buffers the returned groups in a FIFO that decode drains. A redirect squashes everything in flight.
module ifu_fetch_queue #(
  parameter int                         FETCH_WIDTH     = 2,
  parameter int                         INST_ADDR_WIDTH = 32,
  parameter int                         QUEUE_DEPTH     = 8,
  parameter logic [INST_ADDR_WIDTH-1:0] RESET_PC        = '0
) (
  input  logic             clk,
  input  logic             reset,
  ifu_fetch_queue_if.master bus
);
  localparam int PTR_W  = $clog2(QUEUE_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int DATA_W = 32 * FETCH_WIDTH;
  localparam logic [INST_ADDR_WIDTH-1:0] GROUP_BYTES = INST_ADDR_WIDTH'(4 * FETCH_WIDTH);

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_SB   = 2'd1,
    SEL_UJ   = 2'd2,
    SEL_JALR = 2'd3
  } redirect_sel_e;

  logic [INST_ADDR_WIDTH-1:0] r_fetch_pc;
  logic [INST_ADDR_WIDTH-1:0] r_inflight_pc;
  logic                       r_inflight;
  logic [CNT_W-1:0]           r_count;
  logic [PTR_W-1:0]           r_head;
  logic [PTR_W-1:0]           r_tail;
  logic [DATA_W-1:0]          r_inst_mem [QUEUE_DEPTH];
  logic [INST_ADDR_WIDTH-1:0] r_pc_mem   [QUEUE_DEPTH];

  redirect_sel_e              w_sel;
  logic                       w_redirect;
  logic [INST_ADDR_WIDTH-1:0] w_target;
  logic [CNT_W:0]             w_occupancy;
  logic                       w_req;
  logic                       w_enq;
  logic                       w_deq;
  logic                       w_out_valid;

  assign w_sel      = redirect_sel_e'(bus.redirect_sel);
  assign w_redirect = bus.redirect_valid && (w_sel != SEL_NONE);

  // NOTE: w_target gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    w_target = '0;
    case (w_sel)
      SEL_SB:   w_target = bus.sb_type_addr;
      SEL_UJ:   w_target = bus.uj_type_addr;
      SEL_JALR: w_target = bus.jalr_type_addr;
      default:  w_target = '0;
    endcase
    w_target[1:0] = 2'b00;
  end

  // Space is judged on registered count only; a same-cycle dequeue does not open a slot.
  assign w_occupancy = {1'b0, r_count} + (CNT_W + 1)'(r_inflight);
  assign w_req       = !reset && !w_redirect && (w_occupancy < (CNT_W + 1)'(QUEUE_DEPTH));
  assign w_enq       = r_inflight && !w_redirect;
  assign w_out_valid = (r_count != '0);
  assign w_deq       = w_out_valid && bus.out_ready;

  // NOTE: all state here updates with non-blocking assignments so every read sees pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fetch_pc    <= RESET_PC;
      r_inflight_pc <= '0;
      r_inflight    <= 1'b0;
      r_count       <= '0;
      r_head        <= '0;
      r_tail        <= '0;
    end else if (w_redirect) begin
      r_fetch_pc <= w_target;
      r_inflight <= 1'b0;
      r_count    <= '0;
      r_head     <= '0;
      r_tail     <= '0;
    end else begin
      r_inflight <= w_req;
      if (w_req) begin
        r_fetch_pc    <= r_fetch_pc + GROUP_BYTES;
        r_inflight_pc <= r_fetch_pc;
      end
      if (w_enq) r_tail <= r_tail + PTR_W'(1);
      if (w_deq) r_head <= r_head + PTR_W'(1);
      r_count <= r_count + CNT_W'(w_enq) - CNT_W'(w_deq);
    end
  end

  // NOTE: the group storage has no reset; r_count gates out_valid, so stale slots are never visible.
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_inst_mem[r_tail] <= bus.imem_rdata;
      r_pc_mem[r_tail]   <= r_inflight_pc;
    end
  end

  assign bus.imem_req_valid = w_req;
  assign bus.imem_req_addr  = r_fetch_pc;
  assign bus.out_valid      = w_out_valid;
  assign bus.out_inst       = r_inst_mem[r_head];
  assign bus.out_pc         = r_pc_mem[r_head];
  assign bus.out_pc_plus_4  = r_pc_mem[r_head] + INST_ADDR_WIDTH'(4);
  assign bus.queue_count    = r_count;
endmodule

// File: tb/tb_ifu_fetch_queue.sv
// Bench for ifu_fetch_queue: directed phases drive redirects/backpressure and push the expected
// output PCs; a negedge monitor pops and compares every group decode accepts.
module tb_ifu_fetch_queue;
  localparam int FW  = 2;
  localparam int IAW = 32;
  localparam int QD  = 8;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  logic [IAW-1:0]    exp_q[$];
  logic [IAW-1:0]    imem_addr_q;
  logic [IAW-1:0]    mon_pc;
  logic [32*FW-1:0]  mon_inst;

  ifu_fetch_queue_if #(.FETCH_WIDTH(FW), .INST_ADDR_WIDTH(IAW), .QUEUE_DEPTH(QD)) bus ();

  ifu_fetch_queue #(
    .FETCH_WIDTH(FW), .INST_ADDR_WIDTH(IAW), .QUEUE_DEPTH(QD), .RESET_PC(32'h0)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.master)
  );

  always #5 clk = ~clk;

  // Instruction memory: lane i of the group holds its own address (base + 4i), one cycle later.
  always @(posedge clk) imem_addr_q <= bus.imem_req_addr;
  always_comb begin
    for (int i = 0; i < FW; i++) bus.imem_rdata[32*i +: 32] = imem_addr_q + 32'(4 * i);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_req(input string name, input logic exp_valid, input logic [IAW-1:0] exp_addr);
    check({name, "_valid"}, 64'(bus.imem_req_valid), 64'(exp_valid));
    if (exp_valid) check({name, "_addr"}, 64'(bus.imem_req_addr), 64'(exp_addr));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic push_pcs(input logic [IAW-1:0] base, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(base + 32'(8 * i));
  endtask

  task automatic set_redirect(input logic v, input logic [1:0] sel, input logic [IAW-1:0] sb,
                              input logic [IAW-1:0] uj, input logic [IAW-1:0] jalr);
    bus.redirect_valid = v;
    bus.redirect_sel   = sel;
    bus.sb_type_addr   = sb;
    bus.uj_type_addr   = uj;
    bus.jalr_type_addr = jalr;
  endtask

  // Scoreboard monitor: every accepted group must be the next expected one.
  always @(negedge clk) begin
    if (!reset && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected: got out_pc 0x%0h, required no output (t=%0t)", bus.out_pc, $time);
      end else begin
        mon_pc = exp_q.pop_front();
        for (int i = 0; i < FW; i++) mon_inst[32*i +: 32] = mon_pc + 32'(4 * i);
        check("sb_out_pc", 64'(bus.out_pc), 64'(mon_pc));
        check("sb_out_inst", 64'(bus.out_inst), 64'(mon_inst));
        check("sb_out_pc_plus_4", 64'(bus.out_pc_plus_4), 64'(mon_pc + 32'd4));
      end
    end
  end

  initial begin
    #5000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    bus.out_ready = 1'b1;
    set_redirect(1'b0, 2'd0, '0, '0, '0);
    tick();
    settle();
    check_req("rst_req", 1'b0, '0);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_count", 64'(bus.queue_count), 64'd0);
    tick();

    // Streaming with decode always ready.
    push_pcs(32'h0, 6);
    reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      settle();
      check_req($sformatf("p1_req%0d", k), 1'b1, 32'(8 * k));
      if (k == 4) check("p1_count", 64'(bus.queue_count), 64'd1);
      tick();
    end

    // Backpressure from reset until the queue is full, then drain.
    reset = 1'b1;
    bus.out_ready = 1'b0;
    settle();
    check("p2_rst_count", 64'(bus.queue_count), 64'd0);
    check("p2_rst_out_valid", 64'(bus.out_valid), 64'd0);
    tick();
    push_pcs(32'h0, 10);
    reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      settle();
      check_req($sformatf("p2_req%0d", k), 1'b1, 32'(8 * k));
      tick();
    end
    settle();
    check_req("p2_stall_inflight", 1'b0, '0);
    check("p2_count7", 64'(bus.queue_count), 64'd7);
    tick();
    settle();
    check_req("p2_stall_full", 1'b0, '0);
    check("p2_count8", 64'(bus.queue_count), 64'd8);
    tick();
    bus.out_ready = 1'b1;
    settle();
    check_req("p2_no_early_free", 1'b0, '0);
    check("p2_head_pc", 64'(bus.out_pc), 64'h0);
    tick();
    settle();
    check_req("p2_resume", 1'b1, 32'h40);
    tick();
    for (int k = 0; k < 8; k++) tick();

    // SB redirect with three groups queued and one in flight.
    reset = 1'b1;
    bus.out_ready = 1'b0;
    settle();
    tick();
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      settle();
      check_req($sformatf("p3_req%0d", k), 1'b1, 32'(8 * k));
      tick();
    end
    set_redirect(1'b1, 2'd1, 32'h20, 32'h1000, 32'h2000);
    settle();
    check("p3_count3", 64'(bus.queue_count), 64'd3);
    check_req("p3_redir_blocks", 1'b0, '0);
    tick();
    set_redirect(1'b0, 2'd0, '0, '0, '0);
    bus.out_ready = 1'b1;
    push_pcs(32'h20, 3);
    settle();
    check("p3_flushed_count", 64'(bus.queue_count), 64'd0);
    check("p3_flushed_valid", 64'(bus.out_valid), 64'd0);
    check_req("p3_target", 1'b1, 32'h20);
    tick();
    settle();
    check("p3_t2_valid", 64'(bus.out_valid), 64'd0);
    check_req("p3_t2", 1'b1, 32'h28);
    tick();
    settle();
    check("p3_t3_valid", 64'(bus.out_valid), 64'd1);
    check("p3_t3_pc", 64'(bus.out_pc), 64'h20);
    tick();
    tick();

    // JALR redirect with a misaligned target.
    set_redirect(1'b1, 2'd3, 32'h20, 32'h1000, 32'h17);
    settle();
    check_req("p4_jalr_blocks", 1'b0, '0);
    tick();
    set_redirect(1'b0, 2'd0, '0, '0, '0);
    bus.out_ready = 1'b0;
    push_pcs(32'h14, 1);
    settle();
    check_req("p4_jalr_target", 1'b1, 32'h14);
    check("p4_jalr_count", 64'(bus.queue_count), 64'd0);
    tick();
    for (int k = 0; k < 8; k++) tick();

    // UJ redirect to 0 while dequeuing from a full queue.
    bus.out_ready = 1'b1;
    set_redirect(1'b1, 2'd2, 32'h20, 32'h0, 32'h17);
    settle();
    check("p4_full_count", 64'(bus.queue_count), 64'd8);
    check("p4_full_head", 64'(bus.out_pc), 64'h14);
    tick();
    set_redirect(1'b0, 2'd0, '0, '0, '0);
    push_pcs(32'h0, 4);
    settle();
    check("p4_uj_count", 64'(bus.queue_count), 64'd0);
    check("p4_uj_valid", 64'(bus.out_valid), 64'd0);
    check_req("p4_uj_target", 1'b1, 32'h0);
    tick();
    tick();
    tick();
    set_redirect(1'b1, 2'd0, 32'h100, 32'h100, 32'h100);
    settle();
    check_req("p4_sel0_ignored", 1'b1, 32'h18);
    tick();
    set_redirect(1'b0, 2'd0, '0, '0, '0);
    tick();

    // Back-to-back redirects: the last one wins.
    set_redirect(1'b1, 2'd2, 32'h100, 32'h40, 32'h100);
    settle();
    check_req("p5_uj_blocks", 1'b0, '0);
    tick();
    set_redirect(1'b1, 2'd1, 32'h80, 32'h40, 32'h100);
    settle();
    check_req("p5_sb_blocks", 1'b0, '0);
    check("p5_sb_valid", 64'(bus.out_valid), 64'd0);
    tick();
    set_redirect(1'b0, 2'd0, '0, '0, '0);
    bus.out_ready = 1'b0;
    settle();
    check_req("p5_first_req", 1'b1, 32'h80);
    tick();
    for (int k = 0; k < 5; k++) tick();

    // Half-cycle asynchronous reset mid-stream.
    settle();
    check("p6_pre_count", 64'(bus.queue_count), 64'd5);
    check("p6_pre_valid", 64'(bus.out_valid), 64'd1);
    reset = 1'b1;
    #1;
    check("p6_async_count", 64'(bus.queue_count), 64'd0);
    check("p6_async_valid", 64'(bus.out_valid), 64'd0);
    check_req("p6_async_req", 1'b0, '0);
    @(negedge clk);
    #1;
    reset = 1'b0;
    #1;
    check_req("p6_reset_pc", 1'b1, 32'h0);
    tick();
    bus.out_ready = 1'b1;
    push_pcs(32'h0, 4);
    settle();
    check_req("p6_second", 1'b1, 32'h8);
    tick();
    for (int k = 0; k < 4; k++) tick();
    bus.out_ready = 1'b0;
    tick();
    tick();
    settle();
    check("sb_drained", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
